mult_div_unit: RTL
==================

# mult_div_unit

- Iterative HI/LO multiply/divide unit for the MIPS core.
- Sits in EX, directly downstream of the register file: it takes the two register read operands (rs, rt) and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Raises `busy` so the hazard logic stalls any MFHI/MFLO or new HI/LO operation until the result is written.

## Interface
Parameters:
- (none): data width is fixed at 32 by the ISA.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; returns the unit to IDLE and clears HI/LO.
- start  in  1  issue pulse; sampled on posedge while in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored).
- rs_data  in  32  operand A / dividend / MTHI-MTLO source.
- rt_data  in  32  operand B / divisor.
- flush  in  1  synchronous abort of an in-flight operation (branch/exception squash).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after HI/LO are written by a mult/div.
- hi  out  32  architectural HI register, read directly by MFHI.
- lo  out  32  architectural LO register, read directly by MFLO.

## Operation
- States:
  - IDLE.
  - MUL: 32 shift-add iterations.
  - DIV: 32 restoring iterations.
  - FIX: sign correction and HI/LO write.
- IDLE, start=1:
  - MULT/MULTU/DIV/DIVU latch operands, clear the 6-bit iteration counter, and go to MUL or DIV.
  - MTHI/MTLO write hi/lo (rs_data) at that edge, stay in IDLE, busy stays 0, no done pulse.
  - A reserved op is ignored.
- Signed ops:
  - Operands are converted to magnitudes on latch.
  - Result sign: product = sA^sB; quotient = sA^sB; remainder = sA.
- MUL: 64-bit accumulator with a 32-bit multiplicand. One bit per cycle, LSB first. Exits to FIX after iteration 31 (counter == 31).
- DIV: 64-bit remainder/quotient shift register, one restoring step per cycle. Exits to FIX after iteration 31.
- FIX:
  - Applies two's-complement negation per the result-sign rules, then writes hi/lo.
  - Mult writes {hi, lo} = 64-bit product.
  - Div writes lo = quotient, hi = remainder.
  - Then goes to IDLE and pulses done.
- Divide by zero (rt_data == 0), DIV and DIVU:
  - lo = 0xFFFFFFFF, hi = rs_data unmodified; sign correction is suppressed.
- Signed overflow (0x80000000 / -1): lo = 0x80000000, hi = 0, produced naturally by the magnitude path.
- start while busy is ignored, including MTHI/MTLO. Upstream must hold the instruction while busy=1.
- flush=1 in MUL/DIV/FIX: go to IDLE at the next edge; hi/lo unchanged; no done pulse. flush has priority over the FIX write. flush in IDLE has no effect and also blocks a same-cycle start.
- reset (any time, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, operand registers=0.

## Timing
- Edge E0 accepts start:
  - busy=1 from E0 until E33.
  - E1..E32: the 32 iterations.
  - At E33, FIX writes hi/lo, busy falls, and done=1 for the cycle after E33.
- Total mult/div latency: 33 cycles from the accepting edge to hi/lo valid.
- A new start is accepted in the cycle where done=1, because state is IDLE.
- MTHI/MTLO latency: 1 edge; the new value is visible on hi/lo in the next cycle.
- hi and lo are registered outputs; they never change except at an MTHI/MTLO edge, an E33 FIX edge, or reset.

## Configuration
- MDU_DIV_EN defined: the divider datapath, DIV state and divide-by-zero logic are compiled in, and DIV/DIVU behave as above.
- MDU_DIV_EN undefined: DIV/DIVU are treated as reserved ops.
  - The start is ignored, busy stays 0, and hi/lo are unchanged.
  - No divider logic is synthesized.
  - MULT/MULTU/MTHI/MTLO timing is identical in both builds.

## Test plan
- MULT rs=0xFFFFFFFF rt=0x00000002 -> 33 cycles later hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse; MULTU, same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=0x12345678 rt=0 -> lo=0xFFFFFFFF, hi=0x12345678. Without MDU_DIV_EN -> busy stays 0, hi/lo unchanged.
- MTHI rs=0xCAFEBABE, then MTLO rs=0x1 -> hi=0xCAFEBABE and lo=0x1 each one edge later; an MTLO issued while a MULT is busy -> ignored, lo takes the MULT result.
- Start MULT 3*5, assert flush on cycle 10 -> busy drops after one edge, no done, hi/lo keep prior values. Repeat with reset on cycle 20 -> hi=lo=0, busy=0 immediately.
- Back-to-back: MULTU 7*6, then a new start in the done cycle (DIVU 100/7) -> lo=42 after the first op; then lo=14, hi=2 exactly 33 cycles after the second accept.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU, MTHI/MTLO.
// Define MDU_DIV_EN to compile in the divider; otherwise DIV/DIVU are treated as reserved ops.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t      state;
   logic [5:0]  count;
   logic [63:0] acc;
   logic [31:0] opb;
   logic        neg_main;
`ifdef MDU_DIV_EN
   logic        neg_rem;
   logic        is_div;
`endif

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      mag32 = (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
      neg32 = en ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
      neg64 = en ? (~v + 64'd1) : v;
   endfunction

   logic        op_signed, op_mul, op_mthi, op_mtlo;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;

   assign op_signed = ~op[0];
   assign op_mul    = (op[2:1] == 2'b00);
   assign op_mthi   = (op == 3'b100);
   assign op_mtlo   = (op == 3'b101);

   // acc holds {partial product, unconsumed multiplier bits}; add then shift right
   assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opb : 32'd0)};
   assign mul_next = {mul_sum, acc[31:1]};

`ifdef MDU_DIV_EN
   logic        op_div, div_zero;
   logic [33:0] div_trial;
   logic [63:0] div_next;

   assign op_div    = (op[2:1] == 2'b01);
   assign div_zero  = (rt_data == 32'd0);
   // acc holds {partial remainder, dividend/quotient}; trial-subtract the shifted remainder
   assign div_trial = {1'b0, acc[63:31]} - {2'b00, opb};
   assign div_next  = div_trial[33] ? {acc[62:0], 1'b0}
                                    : {div_trial[31:0], acc[30:0], 1'b1};
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count    <= 6'd0;
         acc      <= 64'd0;
         opb      <= 32'd0;
         neg_main <= 1'b0;
`ifdef MDU_DIV_EN
         neg_rem  <= 1'b0;
         is_div   <= 1'b0;
`endif
         hi       <= 32'd0;
         lo       <= 32'd0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !flush) begin
                  if (op_mul) begin
                     acc      <= {32'd0, mag32(rs_data, op_signed)};
                     opb      <= mag32(rt_data, op_signed);
                     neg_main <= op_signed & (rs_data[31] ^ rt_data[31]);
`ifdef MDU_DIV_EN
                     is_div   <= 1'b0;
`endif
                     count    <= 6'd0;
                     state    <= MUL;
                  end
`ifdef MDU_DIV_EN
                  else if (op_div) begin
                     // A zero divisor keeps the raw dividend so it falls out unchanged as the remainder
                     acc      <= {32'd0, div_zero ? rs_data : mag32(rs_data, op_signed)};
                     opb      <= mag32(rt_data, op_signed);
                     neg_main <= op_signed & ~div_zero & (rs_data[31] ^ rt_data[31]);
                     neg_rem  <= op_signed & ~div_zero & rs_data[31];
                     is_div   <= 1'b1;
                     count    <= 6'd0;
                     state    <= DIV;
                  end
`endif
                  else if (op_mthi) begin
                     hi <= rs_data;
                  end else if (op_mtlo) begin
                     lo <= rs_data;
                  end
               end
            end
            MUL: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  acc   <= mul_next;
                  count <= count + 6'd1;
                  if (count == 6'd31) state <= FIX;
               end
            end
`ifdef MDU_DIV_EN
            DIV: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  acc   <= div_next;
                  count <= count + 6'd1;
                  if (count == 6'd31) state <= FIX;
               end
            end
`endif
            FIX: begin
               if (!flush) begin
`ifdef MDU_DIV_EN
                  if (is_div) begin
                     lo <= neg32(acc[31:0], neg_main);
                     hi <= neg32(acc[63:32], neg_rem);
                  end else begin
                     {hi, lo} <= neg64(acc, neg_main);
                  end
`else
                  {hi, lo} <= neg64(acc, neg_main);
`endif
                  done <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
